// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of every bus between the two requesters, the
// arbiter and the shared single-port RAM.
//   I port : i_req, i_addr (to arbiter); i_rdata, i_ack (from arbiter)
//   D port : d_req, d_we, d_addr, d_wdata (to arbiter); d_rdata, d_ack
//   RAM    : mem_addr, mem_data_in, mem_write_en, mem_read_en (from arbiter),
//            mem_data_out (to arbiter)
//   status : busy, owner (from arbiter)
// Modports: slave = arbiter view, master = requester/RAM side view.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface ram_arbiter_if #(parameter int DW = `DATA_WIDTH);
    logic          i_req;
    logic [DW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [DW-1:0] mem_data_out;

    logic          busy;
    logic          owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_rdata, i_ack, d_rdata, d_ack,
               mem_addr, mem_data_in, mem_write_en, mem_read_en, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_rdata, i_ack, d_rdata, d_ack,
               mem_addr, mem_data_in, mem_write_en, mem_read_en, busy, owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares one RAM between an instruction-fetch port (I, read
// only) and a data port (D, read/write). One access per 3 cycles:
// IDLE (accept at edge N) -> ACCESS (cycle N+1, enables on) -> RESP (cycle
// N+2, ack + read data) -> IDLE.
// Ports: clk, rst_n (synchronous, active low), bus (ram_arbiter_if.slave).
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on conflict
// (I first after reset); otherwise D always wins a conflict.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ram_arbiter #(
    parameter int DW = `DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic          owner_q;
    logic          we_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          grant_d;
    logic          in_access;
    logic          in_resp;
    logic          resp_rd;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when D should win the next conflict; cleared by reset so I goes first.
    logic rr_next_d;
`endif

    always_comb begin
        grant_d = bus.d_req;
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = rr_next_d;
`else
            grant_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_next_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state   <= ACCESS;
                        owner_q <= grant_d;
                        if (grant_d) begin
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                            we_q    <= bus.d_we;
                        end else begin
                            addr_q  <= bus.i_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        rr_next_d <= ~grant_d;
`endif
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    state <= IDLE;
                    if (!we_q) begin
                        if (owner_q) d_rdata_q <= bus.mem_data_out;
                        else         i_rdata_q <= bus.mem_data_out;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enables and acks are gated by rst_n so a reset landing mid-transaction
    // can never commit a write or signal completion at the reset edge.
    assign in_access = (state == ACCESS) && rst_n;
    assign in_resp   = (state == RESP) && rst_n;
    assign resp_rd   = in_resp && !we_q;

    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_write_en = in_access && we_q;
    assign bus.mem_read_en  = in_access && !we_q;

    assign bus.i_ack = in_resp && !owner_q;
    assign bus.d_ack = in_resp && owner_q;

    // Read data is forwarded during RESP so it is valid alongside ack, and is
    // registered at the end of RESP so it holds until the next read.
    assign bus.i_rdata = (resp_rd && !owner_q) ? bus.mem_data_out : i_rdata_q;
    assign bus.d_rdata = (resp_rd && owner_q)  ? bus.mem_data_out : d_rdata_q;

    assign bus.busy  = (state != IDLE);
    assign bus.owner = owner_q;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL use parameter DW, default `DATA_WIDTH (32), as the width of every address and data bus below.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have ports for instruction-fetch requester I (read-only): i_req in 1, i_addr in DW, i_rdata out DW, i_ack out 1.
REQ-005 The block SHALL have ports for data requester D: d_req in 1, d_we in 1 (1=write), d_addr in DW, d_wdata in DW, d_rdata out DW, d_ack out 1.
REQ-006 The block SHALL have ports to the shared ram64: mem_addr out DW, mem_data_in out DW, mem_write_en out 1, mem_read_en out 1, mem_data_out in DW.
REQ-007 The block SHALL have status ports busy out 1 (FSM not IDLE) and owner out 1 (0=I, 1=D; current or last grant).

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-009 IDLE: if any req=1 at edge N, the FSM SHALL latch winner, address, write data and we, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-010 ACCESS (cycle N+1): mem_addr and mem_data_in SHALL come from the latched values; mem_write_en=we and mem_read_en=!we; then go to RESP.
REQ-011 RESP (cycle N+2): mem enables SHALL be 0; on a read, mem_data_out SHALL be captured into the winner's rdata register; the winner's ack SHALL be 1 for exactly this cycle; then go to IDLE.
REQ-012 Fixed latency: ack SHALL be asserted 2 cycles after the request edge; the throughput limit SHALL be one access per 3 cycles.
REQ-013 A write SHALL pulse d_ack and SHALL leave d_rdata unchanged.
REQ-014 i_rdata and d_rdata SHALL hold their last captured value until that port's next read completes.
REQ-015 Requesters SHALL hold req and payload stable until ack; req=1 in the cycle after ack SHALL count as a new request.
REQ-016 A req dropped mid-transaction SHALL NOT abort the transaction: the access completes and ack still pulses.
REQ-017 Requests arriving while busy=1 SHALL be ignored until IDLE; they SHALL NOT be queued.
REQ-018 The non-granted port's ack SHALL stay 0 at all times.
REQ-019 mem_write_en and mem_read_en SHALL never both be 1, and both SHALL be 0 outside ACCESS.
REQ-020 Simultaneous i_req and d_req in IDLE SHALL be resolved per REQ-024/REQ-025.

Reset
REQ-021 With rst_n=0 at an edge, the FSM SHALL go to IDLE and i_ack, d_ack, mem_write_en, mem_read_en, busy and owner SHALL be 0; i_rdata, d_rdata, mem_addr and mem_data_in SHALL be 0.
REQ-022 Reset during ACCESS or RESP SHALL abort the transaction: no ack, and no write after the reset edge.
REQ-023 The first request SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-024 With macro ARB_ROUND_ROBIN_EN defined, a conflict SHALL grant the port not granted last (owner inverted); after reset, I wins first.
REQ-025 Without ARB_ROUND_ROBIN_EN, a conflict SHALL always grant D (fixed priority); I may starve.

Verification
REQ-026 Bench SHALL check: d_req=1, d_we=1, d_addr=10, d_wdata=DEADBEEF -> mem_write_en=1 exactly in cycle N+1, d_ack in cycle N+2; then D read of address 10 -> d_rdata=DEADBEEF with d_ack.
REQ-027 Bench SHALL check: I read of address 20 never written -> i_rdata=00000000, i_ack in cycle N+2, d_ack stays 0.
REQ-028 Bench SHALL check: i_req and d_req held high continuously -> with the macro, grants alternate I,D,I,D (acks every 3 cycles); without it, only D is granted.
REQ-029 Bench SHALL check: D writes CAFEBABE to address 30 and d_req drops in cycle N+1 -> write still occurs and d_ack pulses; I read of address 30 returns CAFEBABE.
REQ-030 Bench SHALL check: rst_n=0 asserted during ACCESS of a write to address 5 -> no ack, enables 0, and a later read of address 5 returns the prior contents.
REQ-031 Bench SHALL check: i_req raised while busy=1 and held -> the request is served only after return to IDLE, with i_ack 2 cycles after acceptance.
